multicycle_core: RTL and testbench

Parametrised multi-cycle successor to the single-cycle CPU top. One FSM sequences fetch, decode, execute, memory and writeback over a shared datapath. Instruction and data memories are external and reached through req/valid handshakes, so wait-states are tolerated. Adds branch, jump, load/store and halt, none of which the single-cycle datapath resolves.

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/regfile_param.sv | 40 ++++
 rtl/multicycle_core.sv | 203 ++++++++++++++++++++
 tb/tb_multicycle_core.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for multicycle_core.
//   - opcode encodings (instr[31:28])
//   - instruction field bit positions
//   - FSM state enumeration
package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SLT  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_J    = 4'h9;
  localparam logic [3:0] OP_MUL  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 28;
  localparam int unsigned RS_MSB  = 27;
  localparam int unsigned RS_LSB  = 23;
  localparam int unsigned RT_MSB  = 22;
  localparam int unsigned RT_LSB  = 18;
  localparam int unsigned RD_MSB  = 17;
  localparam int unsigned RD_LSB  = 13;

  // S_MUL is the second EXEC cycle of MUL; unreachable when MUL is not built.
  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MUL,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

endpackage

// File: rtl/regfile_param.sv
// regfile_param: architectural register file, 2 read / 1 write.
//   Clk, Rst         : clock, synchronous active-high reset (clears all regs)
//   raddr1/rdata1    : combinational read port 1
//   raddr2/rdata2    : combinational read port 2
//   we/waddr/wdata   : synchronous write port; writes to r0 are discarded
// r0 always reads zero.
module regfile_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned IDX_W    = 5
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [IDX_W-1:0]  raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [IDX_W-1:0]  raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];
  end

endmodule

// File: rtl/multicycle_core.sv
// multicycle_core: multi-cycle CPU, FETCH -> DECODE -> EXEC -> (MEM) -> WB.
//   Clk, Rst                  : clock, synchronous active-high reset
//   imem_req/addr/rdata/valid : instruction fetch handshake (addr = PC)
//   dmem_req/we/addr/wdata    : data access request, held until dmem_valid
//   dmem_rdata/valid          : load data / access complete
//   pc_out                    : current PC
//   retire                    : one-cycle pulse per completed instruction
//   halted                    : core stopped by HALT (left only via Rst)
// Optional: define MULTICYCLE_MUL_EN to decode opcode A as MUL (two EXEC
// cycles); otherwise opcode A is a NOP.
module multicycle_core
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned IMM_W    = 13
) (
  input  logic              Clk,
  input  logic              Rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_valid,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic              retire,
  output logic              halted
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  state_t            state;
  logic [31:0]       ir;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] a_q, b_q, alu_q, mdr_q;
`ifdef MULTICYCLE_MUL_EN
  logic [DATA_W-1:0] prod_q;
`endif

  logic [3:0]        op;
  logic [IDX_W-1:0]  rs_idx, rt_idx, rd_idx, wr_idx;
  logic [DATA_W-1:0] imm_sx, alu_res, rdata1, rdata2, wr_data;
  logic [ADDR_W-1:0] pc_inc, pc_ctrl;
  logic              mul_op, to_wb, to_mem, is_halt, is_ctrl, mem_active, rf_we;

  // Decode of the latched instruction; register indices alias modulo NUM_REGS.
  always_comb begin
    op     = ir[OPC_MSB:OPC_LSB];
    rs_idx = IDX_W'(32'(ir[RS_MSB:RS_LSB]) % NUM_REGS);
    rt_idx = IDX_W'(32'(ir[RT_MSB:RT_LSB]) % NUM_REGS);
    rd_idx = IDX_W'(32'(ir[RD_MSB:RD_LSB]) % NUM_REGS);
    imm_sx = {{(DATA_W-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
    mul_op = 1'b0;
`ifdef MULTICYCLE_MUL_EN
    mul_op = (op == OP_MUL);
`endif
    to_wb   = (op <= OP_ADDI);
    to_mem  = (op == OP_LW) || (op == OP_SW);
    is_halt = (op == OP_HALT);
    // BEQ, J and every undefined opcode complete in EXEC.
    is_ctrl = !(to_wb || to_mem || is_halt || mul_op);
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_SLT:  alu_res = ($signed(a_q) < $signed(b_q)) ? DATA_W'(1) : '0;
      OP_ADDI,
      OP_LW,
      OP_SW:   alu_res = a_q + imm_sx;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    pc_inc = pc + ADDR_W'(1);
    case (op)
      OP_BEQ:  pc_ctrl = (a_q == b_q) ? (pc_inc + imm_sx[ADDR_W-1:0]) : pc_inc;
      OP_J:    pc_ctrl = ir[ADDR_W-1:0];
      default: pc_ctrl = pc_inc;
    endcase
  end

  always_comb begin
    rf_we   = (state == S_WB);
    wr_idx  = ((op <= OP_SLT) || mul_op) ? rd_idx : rt_idx;
    wr_data = (op == OP_LW) ? mdr_q : alu_q;
  end

  regfile_param #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_rf (
    .Clk    (Clk),
    .Rst    (Rst),
    .raddr1 (rs_idx),
    .rdata1 (rdata1),
    .raddr2 (rt_idx),
    .rdata2 (rdata2),
    .we     (rf_we),
    .waddr  (wr_idx),
    .wdata  (wr_data)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= S_FETCH;
      pc    <= '0;
      ir    <= '0;
      a_q   <= '0;
      b_q   <= '0;
      alu_q <= '0;
      mdr_q <= '0;
`ifdef MULTICYCLE_MUL_EN
      prod_q <= '0;
`endif
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_valid) begin
            ir    <= imem_rdata;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q   <= rdata1;
          b_q   <= rdata2;
          state <= S_EXEC;
        end
        S_EXEC: begin
          alu_q <= alu_res;
          if (is_halt) begin
            state <= S_HALT;
          end else if (to_mem) begin
            state <= S_MEM;
          end else if (mul_op) begin
`ifdef MULTICYCLE_MUL_EN
            prod_q <= a_q * b_q;
`endif
            state <= S_MUL;
          end else if (to_wb) begin
            state <= S_WB;
          end else begin
            pc    <= pc_ctrl;
            state <= S_FETCH;
          end
        end
`ifdef MULTICYCLE_MUL_EN
        S_MUL: begin
          alu_q <= prod_q;
          state <= S_WB;
        end
`endif
        S_MEM: begin
          if (dmem_valid) begin
            if (op == OP_LW) begin
              mdr_q <= dmem_rdata;
              state <= S_WB;
            end else begin
              pc    <= pc_inc;
              state <= S_FETCH;
            end
          end
        end
        S_WB: begin
          pc    <= pc_inc;
          state <= S_FETCH;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Outputs decode the registered state; Rst masks them so nothing is
  // requested or reported during the reset cycle itself.
  always_comb begin
    mem_active = (state == S_MEM) && !Rst;
    imem_req   = (state == S_FETCH) && !Rst;
    imem_addr  = pc;
    dmem_req   = mem_active;
    dmem_we    = mem_active && (op == OP_SW);
    dmem_addr  = mem_active ? alu_q[ADDR_W-1:0] : '0;
    dmem_wdata = (mem_active && (op == OP_SW)) ? b_q : '0;
    pc_out     = pc;
    halted     = (state == S_HALT) && !Rst;
    retire     = !Rst && ((state == S_WB) ||
                          ((state == S_EXEC) && is_ctrl) ||
                          ((state == S_MEM) && (op == OP_SW) && dmem_valid));
  end

endmodule

// File: tb/tb_multicycle_core.sv
module tb_multicycle_core;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        imem_req, imem_valid;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_valid;
  logic [15:0] dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic [15:0] pc_out;
  logic        retire, halted;

  multicycle_core #(
    .DATA_W   (32),
    .ADDR_W   (16),
    .NUM_REGS (32),
    .IMM_W    (13)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_valid (dmem_valid),
    .pc_out     (pc_out),
    .retire     (retire),
    .halted     (halted)
  );

  always #5 Clk = ~Clk;

  // Memory models with programmable wait-states.
  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  int unsigned iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
  logic        dforce = 1'b0;

  assign imem_rdata = imem[imem_addr[7:0]];
  assign imem_valid = imem_req && (icnt >= iwait);
  assign dmem_rdata = dmem[dmem_addr[7:0]];
  assign dmem_valid = dforce || (dmem_req && (dcnt >= dwait));

  logic [15:0] flog [256];
  int unsigned fcnt = 0, wcnt = 0, unst = 0;
  logic [15:0] wlast = '0;
  logic        pend = 1'b0;
  logic [15:0] s_addr = '0;
  logic [31:0] s_wdata = '0;
  logic        s_we = 1'b0;

  always @(posedge Clk) begin
    icnt <= (imem_req && !imem_valid) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_valid) ? dcnt + 1 : 0;
    if (imem_req && imem_valid) begin
      flog[fcnt[7:0]] <= imem_addr;
      fcnt <= fcnt + 1;
    end
    if (dmem_req && dmem_valid && dmem_we) begin
      dmem[dmem_addr[7:0]] <= dmem_wdata;
      wcnt  <= wcnt + 1;
      wlast <= dmem_addr;
    end
    if (pend && dmem_req &&
        ((dmem_addr !== s_addr) || (dmem_wdata !== s_wdata) || (dmem_we !== s_we)))
      unst <= unst + 1;
    pend    <= dmem_req && !dmem_valid;
    s_addr  <= dmem_addr;
    s_wdata <= dmem_wdata;
    s_we    <= dmem_we;
  end

  int tests = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rf(input int k);
    return dut.u_rf.regs[k];
  endfunction

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] rd,
                                      input logic [12:0] imm);
    return {op, rs, rt, rd, imm};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 32'hF000_0000;
  endtask

  // Holds Rst over two edges; returns at the negedge where Rst drops (cycle 1).
  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic wait_halt(input int unsigned maxc, input string tag);
    for (int unsigned c = 0; c < maxc && !halted; c++) @(negedge Clk);
    chk(tag, 32'(halted), 32'd1);
  endtask

  int unsigned rc [8];
  int unsigned nret;
  int unsigned f0, w0, u0;
  logic [15:0] efetch [9];

  initial begin
    // ---------------- zero-wait ALU program + reset state ----------------
    clear_imem();
    imem[0] = enc(4'h5, 5'd0, 5'd1, 5'd0, 13'd5);
    imem[1] = enc(4'h5, 5'd0, 5'd2, 5'd0, 13'd7);
    imem[2] = enc(4'h0, 5'd1, 5'd2, 5'd3, 13'd0);
    imem[3] = 32'hF000_0000;
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    chk("rst_imem_req",   32'(imem_req),   32'd0);
    chk("rst_dmem_req",   32'(dmem_req),   32'd0);
    chk("rst_dmem_we",    32'(dmem_we),    32'd0);
    chk("rst_dmem_addr",  32'(dmem_addr),  32'd0);
    chk("rst_dmem_wdata", dmem_wdata,      32'd0);
    chk("rst_retire",     32'(retire),     32'd0);
    chk("rst_halted",     32'(halted),     32'd0);
    chk("rst_pc",         32'(pc_out),     32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    nret = 0;
    for (int unsigned cyc = 2; cyc <= 20; cyc++) begin
      @(negedge Clk);
      if (retire && nret < 8) begin rc[nret] = cyc; nret++; end
    end
    chk("zw_nret",   nret,  32'd3);
    chk("zw_ret0",   rc[0], 32'd4);
    chk("zw_ret1",   rc[1], 32'd8);
    chk("zw_ret2",   rc[2], 32'd12);
    chk("zw_r3",     rf(3), 32'd12);
    chk("zw_halted", 32'(halted), 32'd1);
    chk("zw_pc",     32'(pc_out), 32'd3);
    chk("zw_noreq",  32'(imem_req), 32'd0);

    // ---------------- wait-states, SW then LW ----------------
    clear_imem();
    imem[0] = enc(4'h5, 5'd0, 5'd1, 5'd0, 13'd5);
    imem[1] = enc(4'h5, 5'd0, 5'd2, 5'd0, 13'd7);
    imem[2] = enc(4'h0, 5'd1, 5'd2, 5'd3, 13'd0);
    imem[3] = enc(4'h7, 5'd0, 5'd3, 5'd0, 13'd20);
    imem[4] = enc(4'h6, 5'd0, 5'd4, 5'd0, 13'd20);
    imem[5] = 32'hF000_0000;
    iwait = 3; dwait = 2;
    w0 = wcnt; u0 = unst;
    do_reset();
    wait_halt(400, "ws_halt_timeout");
    chk("ws_r4",       rf(4),           32'd12);
    chk("ws_wcount",   wcnt - w0,       32'd1);
    chk("ws_waddr",    32'(wlast),      32'd20);
    chk("ws_dmem20",   dmem[20],        32'd12);
    chk("ws_unstable", unst - u0,       32'd0);
    chk("ws_pc",       32'(pc_out),     32'd5);

    // ---------------- branch / jump / edge cases ----------------
    clear_imem();
    imem[0]    = enc(4'h5, 5'd0, 5'd1, 5'd0, 13'd1);   // ADDI r1,r0,1
    imem[1]    = enc(4'h5, 5'd0, 5'd0, 5'd0, 13'd9);   // ADDI r0,r0,9
    imem[2]    = enc(4'h1, 5'd0, 5'd1, 5'd7, 13'd0);   // SUB r7,r0,r1
    imem[3]    = enc(4'h4, 5'd7, 5'd1, 5'd8, 13'd0);   // SLT r8,r7,r1
    imem[4]    = enc(4'h8, 5'd1, 5'd1, 5'd0, 13'd2);   // BEQ taken -> 7
    imem[7]    = enc(4'h8, 5'd1, 5'd0, 5'd0, 13'd5);   // BEQ not taken -> 8
    imem[8]    = 32'h9000_0030;                         // J 0x30
    imem[8'h30] = enc(4'h5, 5'd0, 5'd10, 5'd0, 13'd3); // ADDI r10,r0,3
    iwait = 0; dwait = 0;
    do_reset();
    f0 = fcnt;
    wait_halt(200, "br_halt_timeout");
    efetch = '{16'h0, 16'h1, 16'h2, 16'h3, 16'h4, 16'h7, 16'h8, 16'h30, 16'h31};
    chk("br_nfetch", fcnt - f0, 32'd9);
    for (int i = 0; i < 9; i++) chk($sformatf("br_fetch%0d", i), 32'(flog[(f0 + i) % 256]), 32'(efetch[i]));
    chk("edge_r1",  rf(1),  32'd1);
    chk("edge_sub", rf(7),  32'hFFFF_FFFF);
    chk("edge_slt", rf(8),  32'd1);
    chk("edge_r0",  rf(10), 32'd3);
    chk("br_pc",    32'(pc_out), 32'h31);

    // ---------------- PC wrap + opcode B NOP ----------------
    clear_imem();
    imem[0]     = 32'h9000_FFFF;   // J 0xFFFF
    imem[8'hFF] = 32'hB000_0000;   // opcode B: NOP
    do_reset();
    f0 = fcnt;
    nret = 0;
    for (int unsigned cyc = 2; cyc <= 10; cyc++) begin
      @(negedge Clk);
      if (retire && nret < 8) begin rc[nret] = cyc; nret++; end
    end
    chk("wrap_f0",   32'(flog[f0 % 256]),       32'h0);
    chk("wrap_f1",   32'(flog[(f0 + 1) % 256]), 32'hFFFF);
    chk("wrap_f2",   32'(flog[(f0 + 2) % 256]), 32'h0);
    chk("wrap_nret", nret,  32'd3);
    chk("wrap_ret0", rc[0], 32'd3);
    chk("wrap_ret1", rc[1], 32'd6);

    // ---------------- MUL (or NOP when not built) ----------------
    clear_imem();
    imem[0] = enc(4'h5, 5'd0, 5'd1, 5'd0, 13'd6);
    imem[1] = enc(4'h5, 5'd0, 5'd2, 5'd0, 13'd7);
    imem[2] = enc(4'hA, 5'd1, 5'd2, 5'd5, 13'd0);
    do_reset();
    nret = 0;
    for (int unsigned cyc = 2; cyc <= 24; cyc++) begin
      @(negedge Clk);
      if (retire && nret < 8) begin rc[nret] = cyc; nret++; end
    end
    chk("mul_nret", nret,  32'd3);
`ifdef MULTICYCLE_MUL_EN
    chk("mul_ret",  rc[2], 32'd13);
    chk("mul_r5",   rf(5), 32'd42);
`else
    chk("mul_ret",  rc[2], 32'd11);
    chk("mul_r5",   rf(5), 32'd0);
`endif

    // ---------------- reset in the middle of MEM ----------------
    clear_imem();
    imem[0] = enc(4'h6, 5'd0, 5'd4, 5'd0, 13'd20);  // LW r4 <- M[20] (holds 12)
    dwait = 1000;
    do_reset();
    for (int unsigned c = 0; c < 20 && !dmem_req; c++) @(negedge Clk);
    chk("rm_req_seen", 32'(dmem_req),  32'd1);
    chk("rm_addr",     32'(dmem_addr), 32'd20);
    w0 = wcnt;
    Rst = 1'b1;
    @(negedge Clk);
    chk("rm_req_drop", 32'(dmem_req), 32'd0);
    chk("rm_pc",       32'(pc_out),   32'd0);
    iwait = 1000;
    Rst = 1'b0;
    @(negedge Clk);
    chk("rm_fetch",    32'(imem_req), 32'd1);
    dforce = 1'b1;
    repeat (4) @(negedge Clk);
    dforce = 1'b0;
    @(negedge Clk);
    chk("rm_r4",       rf(4),       32'd0);
    chk("rm_pc2",      32'(pc_out), 32'd0);
    chk("rm_wcount",   wcnt - w0,   32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
